// File: rtl/card_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : card_pkg
//  Description : Card ids, game-control mode codes and the coin/cost lookup
//                helpers shared by the hand-tally slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package card_pkg;

    // Card ids as carried on the card handler's card_stream
    localparam logic [3:0] CARD_NONE     = 4'd0;
    localparam logic [3:0] CARD_COPPER   = 4'd1;
    localparam logic [3:0] CARD_SILVER   = 4'd2;
    localparam logic [3:0] CARD_GOLD     = 4'd3;
    localparam logic [3:0] CARD_ESTATE   = 4'd4;
    localparam logic [3:0] CARD_DUCHY    = 4'd5;
    localparam logic [3:0] CARD_PROVINCE = 4'd6;
    localparam logic [3:0] CARD_CURSE    = 4'd7;
    // ids 8..15 are kingdom cards

    // Phase codes from game control
    localparam logic [2:0] MODE_IDLE    = 3'd0;
    localparam logic [2:0] MODE_DRAW    = 3'd1;
    localparam logic [2:0] MODE_ACTION  = 3'd2;
    localparam logic [2:0] MODE_BUY     = 3'd3;
    localparam logic [2:0] MODE_CLEANUP = 3'd4;

    // Coins a card contributes when held in hand
    function automatic logic [1:0] coin_value(input logic [3:0] card);
        case (card)
            CARD_COPPER: coin_value = 2'd1;
            CARD_SILVER: coin_value = 2'd2;
            CARD_GOLD:   coin_value = 2'd3;
            default:     coin_value = 2'd0;
        endcase
    endfunction

    // Purchase price. Kingdom cards cost 2..5, cycling with the low id bits
    // (8->2, 9->3, 10->4, 11->5, 12->2, ...).
    function automatic logic [3:0] card_cost(input logic [3:0] card);
        if (card[3]) begin
            card_cost = 4'd2 + {2'b00, card[1:0]};
        end else begin
            case (card)
                CARD_SILVER:   card_cost = 4'd3;
                CARD_GOLD:     card_cost = 4'd6;
                CARD_ESTATE:   card_cost = 4'd2;
                CARD_DUCHY:    card_cost = 4'd5;
                CARD_PROVINCE: card_cost = 4'd8;
                default:       card_cost = 4'd0; // NONE, COPPER, CURSE
            endcase
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/hand_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : hand_buffer
//  Description : HAND_MAX x 4-bit slot register file holding the current hand.
//                Writes append at the write pointer; reads stream out from the
//                read pointer and clear each slot as it is read.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                i_clr           - empty the buffer (slots, both pointers)
//                i_wr_en/i_wr_card - append a card (caller guarantees !o_full)
//                i_rd_en         - consume slot[rd_ptr]
//                o_count         - cards held (= write pointer)
//                o_full          - o_count == HAND_MAX
//                o_rd_done       - every held card has been read out
//                o_rd_card       - slot at the read pointer
//  Revision    : 1.0 - initial release
// ============================================================================
module hand_buffer
    import card_pkg::*;
#(
    parameter int HAND_MAX = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clr,
    input  logic       i_wr_en,
    input  logic [3:0] i_wr_card,
    input  logic       i_rd_en,
    output logic [3:0] o_count,
    output logic       o_full,
    output logic       o_rd_done,
    output logic [3:0] o_rd_card
);

    logic [3:0]            r_wr_ptr;
    logic [3:0]            r_rd_ptr;
    logic [HAND_MAX*4-1:0] w_slots;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_wr_ptr <= 4'd0;
            r_rd_ptr <= 4'd0;
        end else begin
            if (i_wr_en) r_wr_ptr <= r_wr_ptr + 4'd1;
            if (i_rd_en) r_rd_ptr <= r_rd_ptr + 4'd1;
        end
    end

    // One register per slot; a slot is cleared as soon as it has been read so
    // the buffer is empty again by the time the stream completes.
    for (genvar i = 0; i < HAND_MAX; i++) begin : g_slot
        logic [3:0] r_slot;
        always_ff @(posedge clk) begin
            if (reset || i_clr) begin
                r_slot <= CARD_NONE;
            end else if (i_wr_en && (r_wr_ptr == 4'(i))) begin
                r_slot <= i_wr_card;
            end else if (i_rd_en && (r_rd_ptr == 4'(i))) begin
                r_slot <= CARD_NONE;
            end
        end
        assign w_slots[i*4 +: 4] = r_slot;
    end

    always_comb begin
        o_rd_card = CARD_NONE;
        for (int i = 0; i < HAND_MAX; i++) begin
            if (r_rd_ptr == 4'(i)) o_rd_card = w_slots[i*4 +: 4];
        end
    end

    assign o_count   = r_wr_ptr;
    assign o_full    = (r_wr_ptr == 4'(HAND_MAX));
    assign o_rd_done = (r_rd_ptr == r_wr_ptr);

endmodule
`default_nettype wire

// File: rtl/hand_tally.sv
`default_nettype none
// ============================================================================
//  Module      : hand_tally
//  Description : Captures drawn cards into a hand buffer and tallies coins,
//                arbitrates purchases during the buy phase, and streams the
//                hand back out for discard at cleanup.
//  Ports       : clk, reset        - clock, synchronous active-high reset
//                mode              - phase code from game control
//                next_card/card_in - drawn-card strobe and id
//                end_mode          - current phase finished
//                buy_req/buy_sel   - purchase request and requested card
//                can_buy           - purchase of buy_sel legal now (comb.)
//                buy_ok/buy_err    - purchase accepted / rejected pulses
//                coins, buys_left, hand_count, overflow - tally state
//                disc_valid/disc_card - discard stream
//                hand_done         - cleanup stream complete pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module hand_tally
    import card_pkg::*;
#(
    parameter int HAND_MAX = 8,
    parameter int COIN_W   = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        mode,
    input  logic              next_card,
    input  logic [3:0]        card_in,
    input  logic              end_mode,
    input  logic              buy_req,
    input  logic [3:0]        buy_sel,
    output logic              can_buy,
    output logic              buy_ok,
    output logic              buy_err,
    output logic [COIN_W-1:0] coins,
    output logic [1:0]        buys_left,
    output logic [3:0]        hand_count,
    output logic              overflow,
    output logic              disc_valid,
    output logic [3:0]        disc_card,
    output logic              hand_done
);

    localparam logic [1:0] c_S_IDLE    = 2'd0;
    localparam logic [1:0] c_S_COLLECT = 2'd1;
    localparam logic [1:0] c_S_BUY     = 2'd2;
    localparam logic [1:0] c_S_CLEANUP = 2'd3;

    logic [1:0]        r_state;
    logic [COIN_W-1:0] r_coins;
    logic [1:0]        r_buys;
    logic              r_overflow;
    logic              r_buy_ok;
    logic              r_buy_err;
    logic              r_disc_valid;
    logic [3:0]        r_disc_card;
    logic              r_hand_done;

    logic              w_abort;
    logic              w_take;
    logic              w_clr;
    logic              w_wr_en;
    logic              w_rd_en;
    logic [3:0]        w_count;
    logic              w_full;
    logic              w_rd_done;
    logic [3:0]        w_rd_card;
    logic [3:0]        w_cost;
    logic              w_can_buy;
    logic [COIN_W:0]   w_coin_sum;
    logic [COIN_W-1:0] w_coin_sat;

    hand_buffer #(
        .HAND_MAX (HAND_MAX)
    ) u_hand_buffer (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (w_clr),
        .i_wr_en   (w_wr_en),
        .i_wr_card (card_in),
        .i_rd_en   (w_rd_en),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_rd_done (w_rd_done),
        .o_rd_card (w_rd_card)
    );

    assign w_abort = (r_state != c_S_IDLE) && (mode == MODE_IDLE);
    assign w_take  = next_card && (card_in != CARD_NONE);

    // Accumulate with one guard bit so saturation is a single carry test
    assign w_coin_sum = {1'b0, r_coins} + (COIN_W+1)'(coin_value(card_in));
    assign w_coin_sat = w_coin_sum[COIN_W] ? {COIN_W{1'b1}} : w_coin_sum[COIN_W-1:0];

    // Compare in a width that holds both operands whatever COIN_W is
    assign w_cost    = card_cost(buy_sel);
    assign w_can_buy = (r_state == c_S_BUY) && (r_buys != 2'd0) &&
                       ((COIN_W+4)'(r_coins) >= (COIN_W+4)'(w_cost));

    // Hand buffer control
    always_comb begin
        w_clr   = 1'b0;
        w_wr_en = 1'b0;
        w_rd_en = 1'b0;
        if (w_abort) begin
            w_clr = 1'b1;
        end else begin
            case (r_state)
                c_S_IDLE:    w_clr   = (mode == MODE_DRAW);
                c_S_COLLECT: w_wr_en = w_take && !w_full;
                c_S_CLEANUP: begin
                    w_rd_en = !w_rd_done;
                    w_clr   = w_rd_done;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_S_IDLE;
            r_coins      <= '0;
            r_buys       <= 2'd0;
            r_overflow   <= 1'b0;
            r_buy_ok     <= 1'b0;
            r_buy_err    <= 1'b0;
            r_disc_valid <= 1'b0;
            r_disc_card  <= CARD_NONE;
            r_hand_done  <= 1'b0;
        end else begin
            r_buy_ok     <= 1'b0;
            r_buy_err    <= 1'b0;
            r_disc_valid <= 1'b0;
            r_disc_card  <= CARD_NONE;
            r_hand_done  <= 1'b0;
            if (w_abort) begin
                r_state <= c_S_IDLE;
            end else begin
                case (r_state)
                    c_S_IDLE: begin
                        if (mode == MODE_DRAW) begin
                            r_state    <= c_S_COLLECT;
                            r_coins    <= '0;
                            r_overflow <= 1'b0;
                            r_buys     <= 2'd1;
                        end
                    end
                    c_S_COLLECT: begin
                        if (w_take) begin
                            if (w_full) r_overflow <= 1'b1;
                            else        r_coins    <= w_coin_sat;
                        end
                        if (end_mode) r_state <= c_S_BUY;
                    end
                    c_S_BUY: begin
                        if (buy_req) begin
                            if (w_can_buy) begin
                                r_coins  <= r_coins - COIN_W'(w_cost);
                                r_buys   <= r_buys - 2'd1;
                                r_buy_ok <= 1'b1;
                            end else begin
                                r_buy_err <= 1'b1;
                            end
                        end
                        if (end_mode) r_state <= c_S_CLEANUP;
                    end
                    c_S_CLEANUP: begin
                        if (!w_rd_done) begin
                            r_disc_valid <= 1'b1;
                            r_disc_card  <= w_rd_card;
                        end else begin
                            r_hand_done <= 1'b1;
                            r_state     <= c_S_IDLE;
                        end
                    end
                    default: r_state <= c_S_IDLE;
                endcase
            end
        end
    end

    assign can_buy    = w_can_buy;
    assign buy_ok     = r_buy_ok;
    assign buy_err    = r_buy_err;
    assign coins      = r_coins;
    assign buys_left  = r_buys;
    assign hand_count = w_count;
    assign overflow   = r_overflow;
    assign disc_valid = r_disc_valid;
    assign disc_card  = r_disc_card;
    assign hand_done  = r_hand_done;

endmodule
`default_nettype wire
